// File: rtl/mux_4_if.sv
`default_nettype none
// ============================================================================
// Module   : mux_4_if
// Brief    : Data/select/enable bundle between a driver and the registered
//            4:1 multiplexer, plus the registered result coming back.
// Revision : 1.0  initial release
// ============================================================================
interface mux_4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] d0;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
    logic [1:0]       sel;
    logic             en;
    logic [WIDTH-1:0] z;
    logic             z_valid;

    modport master (
        output d0, d1, d2, d3, sel, en,
        input  z, z_valid
    );

    modport slave (
        input  d0, d1, d2, d3, sel, en,
        output z, z_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_4.sv
`default_nettype none
// ============================================================================
// Module   : mux_4
// Brief    : Registered 4:1 multiplexer with load enable and a sticky
//            "loaded since reset" flag.
// Revision : 1.0  initial release
// ============================================================================
module mux_4 #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  wire logic clk,
    input  wire logic rst_n,
    mux_4_if.slave    bus
);
    logic [3:0]       w_sel_onehot;
    logic [WIDTH-1:0] w_sel_data;
    logic [WIDTH-1:0] z_d;
    logic [WIDTH-1:0] z_q;
    logic             z_valid_d;
    logic             z_valid_q;

    // One-hot decode feeding a flat AND-OR: every candidate has equal standing.
    assign w_sel_onehot = 4'b0001 << bus.sel;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign w_sel_data[gi] = |(w_sel_onehot &
                                      {bus.d3[gi], bus.d2[gi], bus.d1[gi], bus.d0[gi]});
        end
    endgenerate

    always_comb begin
        z_d       = z_q;
        z_valid_d = z_valid_q;
        if (bus.en) begin
            z_d       = w_sel_data;
            z_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z_q       <= RESET_VAL;
            z_valid_q <= 1'b0;
        end else begin
            z_q       <= z_d;
            z_valid_q <= z_valid_d;
        end
    end

    assign bus.z       = z_q;
    assign bus.z_valid = z_valid_q;
endmodule
`default_nettype wire

// File: tb/tb_mux_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4
// Brief    : Directed self-checking bench for mux_4 at WIDTH=1 and WIDTH=8.
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_4;
    localparam logic [7:0] c_RST8 = 8'hA5;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_pass;

    mux_4_if #(.WIDTH(1)) if1 ();
    mux_4_if #(.WIDTH(8)) if8 ();

    mux_4 #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    mux_4 #(.WIDTH(8), .RESET_VAL(c_RST8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d1(input logic [3:0] v);
        {if1.d3, if1.d2, if1.d1, if1.d0} = v;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // Reset with all candidates high and load requested
        rst_n = 1'b0;
        set_d1(4'b1111);
        if1.sel = 2'b00; if1.en = 1'b1;
        if8.d0 = 8'h11; if8.d1 = 8'h22; if8.d2 = 8'h33; if8.d3 = 8'h44;
        if8.sel = 2'b00; if8.en = 1'b1;
        tick(); tick();
        check_val("rst_z1",  {7'd0, if1.z},       8'h00);
        check_val("rst_v1",  {7'd0, if1.z_valid}, 8'h00);
        check_val("rst_z8",  if8.z,               c_RST8);
        check_val("rst_v8",  {7'd0, if8.z_valid}, 8'h00);
        rst_n = 1'b1;
        tick();
        check_val("rel_z1",  {7'd0, if1.z},       8'h01);
        check_val("rel_v1",  {7'd0, if1.z_valid}, 8'h01);
        check_val("rel_z8",  if8.z,               8'h11);

        // Single-cycle pulse on d0
        set_d1(4'b0000); tick();
        check_val("zero_a", {7'd0, if1.z}, 8'h00);
        set_d1(4'b0001); tick();
        check_val("zero_b", {7'd0, if1.z}, 8'h01);
        set_d1(4'b0000); tick();
        check_val("zero_c", {7'd0, if1.z}, 8'h00);

        // Each select code with matching / non-matching candidate high
        for (int s = 0; s < 4; s++) begin
            if1.sel = 2'(s);
            set_d1(4'b0001 << s); tick();
            check_val($sformatf("sel%0d_hit", s), {7'd0, if1.z}, 8'h01);
            set_d1(4'b1111 & ~(4'b0001 << s)); tick();
            check_val($sformatf("sel%0d_miss", s), {7'd0, if1.z}, 8'h00);
        end

        // Hold under en=0
        if1.sel = 2'b00; set_d1(4'b0001); tick();
        check_val("hold_load", {7'd0, if1.z}, 8'h01);
        if1.en = 1'b0; set_d1(4'b0000);
        for (int k = 0; k < 3; k++) begin
            tick();
            check_val($sformatf("hold_%0d", k), {7'd0, if1.z}, 8'h01);
        end
        check_val("hold_v", {7'd0, if1.z_valid}, 8'h01);
        if1.en = 1'b1; tick();
        check_val("hold_rel", {7'd0, if1.z}, 8'h00);

        // Wide data stepping through every select code
        for (int s = 0; s < 4; s++) begin
            if8.sel = 2'(s); tick();
            check_val($sformatf("wide_%0d", s), if8.z, 8'h11 * 8'(s + 1));
        end

        // Reset pulse mid-stream, then resume
        if8.sel = 2'b01; tick();
        check_val("mid_pre", if8.z, 8'h22);
        if8.sel = 2'b10; rst_n = 1'b0; tick();
        check_val("mid_rst_z", if8.z,               c_RST8);
        check_val("mid_rst_v", {7'd0, if8.z_valid}, 8'h00);
        rst_n = 1'b1; if8.sel = 2'b11; tick();
        check_val("mid_res_z", if8.z,               8'h44);
        check_val("mid_res_v", {7'd0, if8.z_valid}, 8'h01);

        // Reset wins over en=0; first load waits for en=1
        if8.en = 1'b0; rst_n = 1'b0; tick();
        check_val("rsten0_z", if8.z,               c_RST8);
        check_val("rsten0_v", {7'd0, if8.z_valid}, 8'h00);
        rst_n = 1'b1; if8.sel = 2'b01; tick();
        check_val("wait_z", if8.z,               c_RST8);
        check_val("wait_v", {7'd0, if8.z_valid}, 8'h00);
        if8.en = 1'b1; tick();
        check_val("first_z", if8.z,               8'h22);
        check_val("first_v", {7'd0, if8.z_valid}, 8'h01);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
